// File: rtl/digi_scan.sv
// ============================================================================
//  Module      : digi_scan
//  Description : Four-digit multiplexed 7-segment scanner with frame-aligned
//                double buffering and optional leading-zero blanking.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module digi_scan #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        blank_en,
    output logic [11:0] digi,
    output logic        frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    localparam logic [1:0] DIGIT_0 = 2'd0;
    localparam logic [1:0] DIGIT_3 = 2'd3;

    localparam logic [11:0] DIGI_RESET = 12'hEC0;
    localparam logic [11:0] DIGI_BLANK = 12'hFFF;

    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       digit_idx;
    logic [15:0]      pending;
    logic             pending_valid;
    logic [15:0]      shadow;

    logic             slot_end;
    logic             frame_end;
    logic [1:0]       digit_nxt;
    logic [15:0]      shadow_nxt;
    logic [3:0]       nibble_nxt;
    logic             blank_nxt;
    logic [11:0]      digi_nxt;

    // Active-low segment pattern, bit order gfedcba.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign slot_end  = (div_cnt == CNT_LAST);
    assign frame_end = slot_end && (digit_idx == DIGIT_3);
    assign digit_nxt = slot_end ? digit_idx + 2'd1 : digit_idx;

    // A write landing on the boundary edge bypasses pending and wins.
    always_comb begin
        shadow_nxt = shadow;
        if (frame_end) begin
            if (wr_en) begin
                shadow_nxt = wr_data;
            end else if (pending_valid) begin
                shadow_nxt = pending;
            end
        end
    end

    // Output is encoded from next-state values so it moves with the index.
    always_comb begin
        nibble_nxt = shadow_nxt[3:0];
        blank_nxt  = 1'b0;
        case (digit_nxt)
            2'd0: begin
                nibble_nxt = shadow_nxt[3:0];
                blank_nxt  = 1'b0;
            end
            2'd1: begin
                nibble_nxt = shadow_nxt[7:4];
                blank_nxt  = blank_en && (shadow_nxt[15:4] == 12'h000);
            end
            2'd2: begin
                nibble_nxt = shadow_nxt[11:8];
                blank_nxt  = blank_en && (shadow_nxt[15:8] == 8'h00);
            end
            default: begin
                nibble_nxt = shadow_nxt[15:12];
                blank_nxt  = blank_en && (shadow_nxt[15:12] == 4'h0);
            end
        endcase

        if (blank_nxt) begin
            digi_nxt = DIGI_BLANK;
        end else begin
            digi_nxt = {~(4'b0001 << digit_nxt), 1'b1, seg_of(nibble_nxt)};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_idx     <= DIGIT_0;
            shadow        <= 16'h0000;
            pending       <= 16'h0000;
            pending_valid <= 1'b0;
        end else begin
            digit_idx <= digit_nxt;
            shadow    <= shadow_nxt;
            if (wr_en) begin
                pending <= wr_data;
            end
            if (frame_end) begin
                pending_valid <= 1'b0;
            end else if (wr_en) begin
                pending_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digi       <= DIGI_RESET;
            frame_done <= 1'b0;
        end else begin
            digi       <= digi_nxt;
            frame_done <= frame_end;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_digi_scan.sv
// ============================================================================
//  Module      : tb_digi_scan
//  Description : Directed self-checking bench for digi_scan with SCAN_DIV=4.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_digi_scan;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        blank_en;
    logic [11:0] digi;
    logic        frame_done;

    int n_cmp;
    int n_bad;
    int cyc;
    int last_fd;
    int pulses;

    digi_scan #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .blank_en   (blank_en),
        .digi       (digi),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one edge; sample 1 ns later and track frame_done spacing.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (frame_done === 1'b1) begin
            if (last_fd >= 0) chk("fd_gap", 16'(cyc - last_fd), 16'd16);
            last_fd = cyc;
            pulses++;
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic write(input logic [15:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; last_fd = -1; pulses = 0;
        reset = 1'b0; wr_en = 1'b0; wr_data = 16'h0; blank_en = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_digi", {4'h0, digi}, 16'h0EC0);
        chk("rst_fd", {15'h0, frame_done}, 16'h0);
        reset = 1'b1;
        cyc = 0;

        // 1234 written in cycle 1; visible only after the boundary at 16
        tick();
        write(16'h1234);
        chk("w_hold", {4'h0, digi}, 16'h0EC0);
        run_to(3);  chk("slot0_end", {4'h0, digi}, 16'h0EC0);
        run_to(4);  chk("slot1", {4'h0, digi}, 16'h0DC0);
        run_to(15); chk("pre_bnd", {4'h0, digi}, 16'h07C0);
                    chk("pre_bnd_fd", {15'h0, frame_done}, 16'h0);
        run_to(16); chk("d0_1234", {4'h0, digi}, 16'h0E99);
                    chk("fd_16", {15'h0, frame_done}, 16'h1);
        run_to(17); chk("fd_17", {15'h0, frame_done}, 16'h0);
        pulses = 0;
        run_to(20); chk("d1_1234", {4'h0, digi}, 16'h0DB0);
        run_to(24); chk("d2_1234", {4'h0, digi}, 16'h0BA4);
        run_to(28); chk("d3_1234", {4'h0, digi}, 16'h07F9);
        run_to(32); chk("d0_again", {4'h0, digi}, 16'h0E99);

        // two writes in one frame: last one wins
        run_to(33); write(16'hAAAA);
        run_to(35); write(16'h000F);
        run_to(47); chk("old_frame", {4'h0, digi}, 16'h07F9);
        run_to(48); chk("d0_F", {4'h0, digi}, 16'h0E8E);
        run_to(52); chk("d1_0", {4'h0, digi}, 16'h0DC0);
        run_to(56); chk("d2_0", {4'h0, digi}, 16'h0BC0);
        run_to(60); chk("d3_0", {4'h0, digi}, 16'h07C0);

        // leading-zero blanking
        run_to(61); blank_en = 1'b1; write(16'h0005);
        run_to(64); chk("blk_d0", {4'h0, digi}, 16'h0E92);
        run_to(68); chk("blk_d1", {4'h0, digi}, 16'h0FFF);
        run_to(72); chk("blk_d2", {4'h0, digi}, 16'h0FFF);
        run_to(76); chk("blk_d3", {4'h0, digi}, 16'h0FFF);
        run_to(77); blank_en = 1'b0; write(16'h0050);
        chk("unblk_d3", {4'h0, digi}, 16'h07C0);
        blank_en = 1'b1;
        run_to(79); chk("reblk_d3", {4'h0, digi}, 16'h0FFF);
        run_to(80); chk("blk_d0_zero", {4'h0, digi}, 16'h0EC0);
        run_to(81); chk("fd_count", 16'(pulses), 16'd4);
        run_to(84); chk("blk_d1_5", {4'h0, digi}, 16'h0D92);
        run_to(88); chk("blk_d2_b", {4'h0, digi}, 16'h0FFF);
        run_to(92); chk("blk_d3_b", {4'h0, digi}, 16'h0FFF);

        // write on the boundary edge bypasses an older pending value
        run_to(93); blank_en = 1'b0; write(16'h1111);
        run_to(95); write(16'h00C0);
        chk("byp_d0", {4'h0, digi}, 16'h0EC0);
        chk("byp_fd", {15'h0, frame_done}, 16'h1);
        run_to(100); chk("byp_d1", {4'h0, digi}, 16'h0DC6);
        run_to(112); chk("byp_nopend", {4'h0, digi}, 16'h0EC0);

        // mid-run reset discards pending data
        run_to(113); write(16'h9999);
        run_to(117);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_digi", {4'h0, digi}, 16'h0EC0);
        chk("mid_rst_fd", {15'h0, frame_done}, 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc = 0;
        last_fd = -1;
        run_to(3);  chk("rel_hold", {4'h0, digi}, 16'h0EC0);
        run_to(4);  chk("rel_d1", {4'h0, digi}, 16'h0DC0);
        run_to(15); chk("rel_d3", {4'h0, digi}, 16'h07C0);
        run_to(16); chk("rel_d0", {4'h0, digi}, 16'h0EC0);
                    chk("rel_fd", {15'h0, frame_done}, 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
